// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Drives one column at a time, senses rows through a 2-flop synchronizer,
// and emits one key_valid pulse with a hex key_code per debounced press.
module keypad_scan_debounce #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [19:0] DEBOUNCE_CNT = 20'd100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r,
    output logic [3:0] c,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  r_meta_q, r_meta_d;
    logic [3:0]  rs_q, rs_d;
    logic [15:0] dwell_q, dwell_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;

    logic        dwell_last;
    logic        cnt_last;
    logic [15:0] dwell_sat;
    logic [19:0] cnt_sat;
    logic [1:0]  low_row;
    logic [3:0]  key_map;

    assign c         = 4'b0001 << col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    // Synchronizer inputs and saturating counter helpers
    always_comb begin
        r_meta_d   = r;
        rs_d       = r_meta_q;
        dwell_last = (({1'b0, dwell_q} + 17'd1) >= {1'b0, SCAN_DIV});
        cnt_last   = (({1'b0, cnt_q} + 21'd1) >= {1'b0, DEBOUNCE_CNT});
        dwell_sat  = (dwell_q == '1) ? dwell_q : dwell_q + 16'd1;
        cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
    end

    // Lowest asserted synchronized row wins when several rows close at once
    always_comb begin
        low_row = 2'd3;
        if (rs_q[0])      low_row = 2'd0;
        else if (rs_q[1]) low_row = 2'd1;
        else if (rs_q[2]) low_row = 2'd2;
    end

    // Hex legend for the latched row/column
    always_comb begin
        key_map = 4'h0;
        case ({row_q, col_q})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            4'hF: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    end

    // Scan / debounce / hold / release next-state and output logic
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (dwell_last) begin
                    dwell_d = '0;
                    if (rs_q != '0) begin
                        row_d   = low_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_sat;
                end
            end
            DEBOUNCE: begin
                if (rs_q[row_q]) begin
                    if (cnt_last) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_map;
                        key_held_d  = 1'b1;
                        cnt_d       = '0;
                        state_d     = HELD;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end else begin
                    cnt_d   = '0;
                    dwell_d = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end
            end
            HELD: begin
                if (rs_q == '0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rs_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_last) begin
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                    dwell_d    = '0;
                    col_d      = col_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            r_meta_q    <= '0;
            rs_q        <= '0;
            dwell_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_meta_q    <= r_meta_d;
            rs_q        <= rs_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a small keypad model.
module tb_keypad_scan_debounce;

    logic        clk;
    logic        reset;
    logic [3:0]  r;
    logic [3:0]  c;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks;
    int failures;
    int pulses;

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } key_vec_t;

    key_vec_t kv[16];

    keypad_scan_debounce #(
        .SCAN_DIV    (16'd4),
        .DEBOUNCE_CNT(20'd8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .r        (r),
        .c        (c),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Keypad model: row i closes when key (i, j) is pressed and column j is driven
    always_comb begin
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = |(pressed[i*4 +: 4] & c);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_held === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_col_entry(input logic [3:0] target, output bit found);
        logic [3:0] pc;
        found = 1'b0;
        pc = c;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pc != target && c == target) begin
                found = 1'b1;
                break;
            end
            pc = c;
        end
    endtask

    initial begin
        bit          ok;
        logic [3:0]  c7;
        logic [3:0]  c8;
        int          run0;
        int          held_drops;
        logic [15:0] one;

        kv[0]  = '{0, 0, 4'h1};  kv[1]  = '{0, 1, 4'h2};
        kv[2]  = '{0, 2, 4'h3};  kv[3]  = '{0, 3, 4'hA};
        kv[4]  = '{1, 0, 4'h4};  kv[5]  = '{1, 1, 4'h5};
        kv[6]  = '{1, 2, 4'h6};  kv[7]  = '{1, 3, 4'hB};
        kv[8]  = '{2, 0, 4'h7};  kv[9]  = '{2, 1, 4'h8};
        kv[10] = '{2, 2, 4'h9};  kv[11] = '{2, 3, 4'hC};
        kv[12] = '{3, 0, 4'hE};  kv[13] = '{3, 1, 4'h0};
        kv[14] = '{3, 2, 4'hF};  kv[15] = '{3, 3, 4'hD};

        checks   = 0;
        failures = 0;
        pulses   = 0;
        pressed  = '0;
        one      = 16'h0001;
        reset    = 1'b0;

        // 1: reset values, then idle scan with 4-cycle dwell
        tick(); tick();
        check("rst_c", 32'(c), 32'h1);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("scan_c", 32'(c), 32'(4'b0001 << ((k / 4) % 4)));
        end
        check("idle_pulses", 32'(pulses), 32'h0);
        check("idle_code", 32'(key_code), 32'h0);

        // Key map: every key pressed alone, one pulse, correct code, column frozen
        for (int n = 0; n < 16; n++) begin
            pulses  = 0;
            pressed = one << (kv[n].row * 4 + kv[n].col);
            wait_valid(80, ok);
            check("map_seen", 32'(ok), 32'h1);
            check("map_code", 32'(key_code), 32'(kv[n].code));
            check("map_col", 32'(c), 32'(4'b0001 << kv[n].col));
            pressed = '0;
            wait_held_low(40, ok);
            check("map_release", 32'(ok), 32'h1);
            check("map_pulses", 32'(pulses), 32'h1);
            for (int i = 0; i < 4; i++) tick();
        end

        // 2: row1/col2 held for 100 cycles
        pulses  = 0;
        pressed = one << 6;
        for (int i = 0; i < 100; i++) tick();
        check("hold_pulses", 32'(pulses), 32'h1);
        check("hold_code", 32'(key_code), 32'h6);
        check("hold_col", 32'(c), 32'h4);
        check("hold_held", 32'(key_held), 32'h1);
        pressed = '0;
        wait_held_low(40, ok);
        check("hold_release", 32'(ok), 32'h1);
        for (int i = 0; i < 8; i++) tick();

        // 3: bouncing press on row2/col0 never qualifies
        pulses = 0;
        wait_col_entry(4'b0001, ok);
        check("bounce_sync", 32'(ok), 32'h1);
        pressed = one << 8;
        run0 = 1;
        c7 = '0;
        c8 = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 7) c7 = c;
            if (i == 8) c8 = c;
            if (c == 4'b0001 && run0 == i) run0++;
            pressed = ((i < 5) || (i >= 7 && i < 12)) ? (one << 8) : 16'h0;
        end
        check("bounce_frozen_len", 32'(run0), 32'd8);
        check("bounce_c7", 32'(c7), 32'h1);
        check("bounce_resume", 32'(c8), 32'h2);
        for (int i = 0; i < 40; i++) tick();
        check("bounce_pulses", 32'(pulses), 32'h0);

        // 4: row3/col3 with glitchy release, then re-press
        pulses  = 0;
        pressed = one << 15;
        wait_valid(80, ok);
        check("glitch_seen", 32'(ok), 32'h1);
        check("glitch_code", 32'(key_code), 32'hD);
        for (int i = 0; i < 20; i++) tick();
        held_drops = 0;
        for (int i = 0; i < 14; i++) begin
            pressed = ((i >= 4 && i < 7) || (i >= 11)) ? (one << 15) : 16'h0;
            tick();
            if (key_held !== 1'b1) held_drops++;
        end
        check("glitch_held_kept", 32'(held_drops), 32'h0);
        pressed = '0;
        for (int i = 0; i < 8; i++) tick();
        check("glitch_held_8", 32'(key_held), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("glitch_held_drop", 32'(key_held), 32'h0);
        check("glitch_pulses", 32'(pulses), 32'h1);
        pressed = one << 15;
        wait_valid(80, ok);
        check("repress_seen", 32'(ok), 32'h1);
        check("repress_pulses", 32'(pulses), 32'h2);
        check("repress_code", 32'(key_code), 32'hD);
        pressed = '0;
        wait_held_low(40, ok);
        check("repress_release", 32'(ok), 32'h1);
        for (int i = 0; i < 8; i++) tick();

        // 5: row0 and row3 together on col0, lowest row wins
        pulses  = 0;
        pressed = (one << 0) | (one << 12);
        for (int i = 0; i < 80; i++) tick();
        check("multi_pulses", 32'(pulses), 32'h1);
        check("multi_code", 32'(key_code), 32'h1);
        pressed = '0;
        wait_held_low(40, ok);
        check("multi_release", 32'(ok), 32'h1);
        for (int i = 0; i < 8; i++) tick();

        // 6: reset asserted mid-debounce on row0/col1
        pulses = 0;
        wait_col_entry(4'b0010, ok);
        check("rstmid_sync", 32'(ok), 32'h1);
        pressed = one << 1;
        for (int i = 0; i < 9; i++) tick();
        check("rstmid_col_frozen", 32'(c), 32'h2);
        check("rstmid_no_pulse", 32'(pulses), 32'h0);
        reset = 1'b0;
        #1;
        check("rstmid_c", 32'(c), 32'h1);
        check("rstmid_held", 32'(key_held), 32'h0);
        check("rstmid_valid", 32'(key_valid), 32'h0);
        check("rstmid_code", 32'(key_code), 32'h0);
        pressed = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("rstmid_after_pulses", 32'(pulses), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
